// File: rtl/ras_resolver.sv
// Return-address-stack prediction resolver: tracks issued return-target predictions
// in a FIFO and checks them in order against execute-stage resolutions.
// Optional hit/miss statistics counters are enabled by defining OPTION_RAS_RESOLVER_STATS_EN.
module ras_resolver #(
  parameter int DEPTH = 4
) (
  input  logic                     s_clk_i,
  input  logic                     s_reset_i,
  input  logic                     s_flush_i,
  input  logic                     s_pred_valid_i,
  input  logic [30:0]              s_pred_addr_i,
  output logic                     s_pred_ready_o,
  input  logic                     s_res_valid_i,
  input  logic                     s_res_pred_i,
  input  logic [30:0]              s_res_target_i,
  output logic                     s_mispredict_o,
  output logic [30:0]              s_redirect_addr_o,
  output logic                     s_error_o,
  output logic [$clog2(DEPTH):0]   s_count_o
`ifdef OPTION_RAS_RESOLVER_STATS_EN
  ,
  output logic [15:0]              s_hits_o,
  output logic [15:0]              s_misses_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [30:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mispredict_q, mispredict_d;
  logic          error_q, error_d;
  logic [30:0]   redirect_q, redirect_d;

  logic enq, res_req, deq, head_match;

  assign s_pred_ready_o = (count_q != FULL_CNT);
  assign enq        = s_pred_valid_i & s_pred_ready_o & ~s_flush_i;
  assign res_req    = s_res_valid_i & s_res_pred_i & ~s_flush_i;
  assign deq        = res_req & (count_q != '0);
  assign head_match = (mem_q[rd_ptr_q] == s_res_target_i);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mispredict_d = 1'b0;
    error_d      = 1'b0;
    redirect_d   = '0;
    if (s_flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // An enqueue in the same cycle cannot satisfy a resolution against an empty FIFO.
      error_d      = res_req & (count_q == '0);
      mispredict_d = error_d | (deq & ~head_match);
      if (mispredict_d) redirect_d = s_res_target_i;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      error_q      <= 1'b0;
      redirect_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      error_q      <= error_d;
      redirect_q   <= redirect_d;
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge s_clk_i) begin
    if (enq && !s_reset_i) mem_q[wr_ptr_q] <= s_pred_addr_i;
  end

  assign s_mispredict_o    = mispredict_q;
  assign s_error_o         = error_q;
  assign s_redirect_addr_o = redirect_q;
  assign s_count_o         = count_q;

`ifdef OPTION_RAS_RESOLVER_STATS_EN
  logic [15:0] hits_q, hits_d;
  logic [15:0] misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (deq && head_match && (hits_q != 16'hFFFF)) hits_d = hits_q + 16'd1;
    if (mispredict_d && (misses_q != 16'hFFFF))    misses_d = misses_q + 16'd1;
  end

  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign s_hits_o   = hits_q;
  assign s_misses_o = misses_q;
`endif

endmodule

// File: doc/ras_resolver.md
RAS_RESOLVER -- requirements
Module: ras_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prediction-tracking entries; power of two, 2..16.
REQ-002 SHALL have s_clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have s_reset_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have s_flush_i  input  1  pipeline flush; discards all tracked predictions.
REQ-005 SHALL have s_pred_valid_i  input  1  predictor issued a return-target prediction this cycle.
REQ-006 SHALL have s_pred_addr_i  input  31  predicted target, halfword address [31:1].
REQ-007 SHALL have s_pred_ready_o  output  1  entry free; a prediction is accepted only when high.
REQ-008 SHALL have s_res_valid_i  input  1  execute stage resolves a return-type jump this cycle.
REQ-009 SHALL have s_res_pred_i  input  1  resolved jump was fetched under a RAS prediction.
REQ-010 SHALL have s_res_target_i  input  31  actual target, halfword address [31:1].
REQ-011 SHALL have s_mispredict_o  output  1  one-cycle pulse; tracked prediction was wrong or missing.
REQ-012 SHALL have s_redirect_addr_o  output  31  correct target, valid while s_mispredict_o is high.
REQ-013 SHALL have s_error_o  output  1  one-cycle pulse; resolution with s_res_pred_i while empty.
REQ-014 SHALL have s_count_o  output  $clog2(DEPTH)+1  number of tracked predictions.

Function
REQ-015 SHALL keep a FIFO of DEPTH entries with read/write pointers wrapping modulo DEPTH and a count register.
REQ-016 SHALL drive s_pred_ready_o = (count != DEPTH); no same-cycle bypass from a dequeue.
REQ-017 SHALL enqueue s_pred_addr_i when s_pred_valid_i & s_pred_ready_o & ~s_flush_i; predictions offered while full are dropped silently.
REQ-018 SHALL dequeue when s_res_valid_i & s_res_pred_i & (count != 0) & ~s_flush_i, comparing head entry against s_res_target_i over all 31 bits.
REQ-019 SHALL, one cycle after a dequeue with mismatch, assert s_mispredict_o and drive s_redirect_addr_o = registered s_res_target_i; match gives no pulse.
REQ-020 SHALL, one cycle after s_res_valid_i & s_res_pred_i with count == 0 and no flush, assert both s_error_o and s_mispredict_o with s_redirect_addr_o = s_res_target_i; an enqueue in the same cycle does not satisfy it.
REQ-021 SHALL ignore s_res_valid_i when s_res_pred_i is low (no dequeue, no pulse).
REQ-022 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and advance both pointers.
REQ-023 SHALL, on s_flush_i, clear pointers and count next cycle, ignore same-cycle enqueue/resolve, and force s_mispredict_o/s_error_o low next cycle.
REQ-024 SHALL hold s_redirect_addr_o at 0 when s_mispredict_o is low.

Reset
REQ-025 SHALL, when s_reset_i is high at a clock edge, set pointers, count, s_mispredict_o, s_error_o, s_redirect_addr_o to 0; s_pred_ready_o reads 1 after reset.
REQ-026 SHALL give reset priority over flush, enqueue and resolve, including mid-operation; FIFO storage contents need no reset.

Configuration
REQ-027 SHALL, with OPTION_RAS_RESOLVER_STATS_EN defined, add outputs s_hits_o and s_misses_o (16 bits each), incrementing per matching dequeue and per s_mispredict_o event respectively.
REQ-028 SHALL saturate both counters at 16'hFFFF, clear them on reset only (not flush).
REQ-029 SHALL, without OPTION_RAS_RESOLVER_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-030 SHALL cover: enqueue 0x00000100, resolve pred=1 target 0x00000100 -> no mispredict, count 1->0, hits=1.
REQ-031 SHALL cover: enqueue 0x00000200, resolve target 0x00000204 -> next cycle s_mispredict_o=1, s_redirect_addr_o=0x00000204, misses=1.
REQ-032 SHALL cover: DEPTH=4, enqueue 5 addresses 0x10..0x14 -> s_pred_ready_o=0 after 4th, 0x14 dropped, resolves match 0x10..0x13 in order with pointer wrap.
REQ-033 SHALL cover: count 2, flush with simultaneous enqueue and resolve -> count 0 next cycle, no pulses.
REQ-034 SHALL cover: empty, resolve pred=1 target 0x00000300 with simultaneous enqueue -> s_error_o=1, s_mispredict_o=1, redirect 0x00000300, count 1.
REQ-035 SHALL cover: count 3, s_reset_i asserted mid-stream with enqueue -> all outputs 0, s_pred_ready_o=1, counters 0.
